// File: rtl/mac_tx_framer.sv
// Ethernet MAC transmit framer: wraps a contiguous body stream with preamble, SFD, zero pad and FCS,
// then holds off the next frame for IFG idle cycles. Outputs registered; rdy is high only in DATA.
module mac_tx_framer #(
   parameter int IFG          = 12,
   parameter int MIN_LEN      = 60,
   parameter int PREAMBLE_LEN = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       vin,
   input  logic       lin,
   output logic       rdy,
   output logic [7:0] dout,
   output logic       vout,
   output logic       err,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, GAP} state_t;

   localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
   localparam logic [15:0] GAP_LAST  = 16'(IFG - 1);
   localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_LEN - 1);

   state_t      state, state_nxt;
   logic [7:0]  dout_nxt;
   logic        vout_nxt, err_nxt;
   logic [31:0] crc, crc_nxt;
   logic [15:0] cnt, cnt_nxt, cnt_inc;
   logic [7:0]  pre_cnt, pre_cnt_nxt;
   logic [1:0]  fcs_idx, fcs_idx_nxt;
   logic [15:0] gap_cnt, gap_cnt_nxt;
   logic        bad, bad_nxt;
   logic [31:0] fcs_word;
   logic [7:0]  fcs_byte;

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h000000, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign rdy     = (state == DATA);
   assign busy    = (state != IDLE);
   assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

   // An aborted frame carries the complement of the true FCS, i.e. the raw CRC register.
   always_comb begin
      fcs_word = bad ? crc : ~crc;
      case (fcs_idx)
         2'd0:    fcs_byte = fcs_word[7:0];
         2'd1:    fcs_byte = fcs_word[15:8];
         2'd2:    fcs_byte = fcs_word[23:16];
         default: fcs_byte = fcs_word[31:24];
      endcase
   end

   always_comb begin
      state_nxt   = state;
      dout_nxt    = 8'h00;
      vout_nxt    = 1'b0;
      err_nxt     = 1'b0;
      crc_nxt     = crc;
      cnt_nxt     = cnt;
      pre_cnt_nxt = pre_cnt;
      fcs_idx_nxt = fcs_idx;
      gap_cnt_nxt = gap_cnt;
      bad_nxt     = bad;
      case (state)
         IDLE: begin
            if (vin) begin
               vout_nxt    = 1'b1;
               crc_nxt     = 32'hFFFFFFFF;
               cnt_nxt     = 16'd0;
               fcs_idx_nxt = 2'd0;
               bad_nxt     = 1'b0;
               if (PREAMBLE_LEN == 0) begin
                  dout_nxt  = 8'hD5;
                  state_nxt = DATA;
               end else begin
                  dout_nxt    = 8'h55;
                  pre_cnt_nxt = 8'd1;
                  state_nxt   = (PREAMBLE_LEN == 1) ? SFD : PRE;
               end
            end
         end
         PRE: begin
            vout_nxt    = 1'b1;
            dout_nxt    = 8'h55;
            pre_cnt_nxt = pre_cnt + 8'd1;
            if (pre_cnt == PRE_LAST)
               state_nxt = SFD;
         end
         SFD: begin
            vout_nxt  = 1'b1;
            dout_nxt  = 8'hD5;
            state_nxt = DATA;
         end
         DATA: begin
            vout_nxt = 1'b1;
            if (vin) begin
               dout_nxt = din;
               crc_nxt  = crc_upd(crc, din);
               cnt_nxt  = cnt_inc;
               if (lin)
                  state_nxt = (cnt_inc < MIN_LEN_W) ? PAD : FCS;
            end else begin
               // Underrun: this cycle already becomes pad or the first FCS byte so vout stays contiguous.
               bad_nxt = 1'b1;
               if (cnt < MIN_LEN_W) begin
                  crc_nxt   = crc_upd(crc, 8'h00);
                  cnt_nxt   = cnt_inc;
                  state_nxt = (cnt_inc >= MIN_LEN_W) ? FCS : PAD;
               end else begin
                  dout_nxt    = crc[7:0];
                  err_nxt     = 1'b1;
                  fcs_idx_nxt = 2'd1;
                  state_nxt   = FCS;
               end
            end
         end
         PAD: begin
            vout_nxt = 1'b1;
            crc_nxt  = crc_upd(crc, 8'h00);
            cnt_nxt  = cnt_inc;
            if (cnt_inc >= MIN_LEN_W)
               state_nxt = FCS;
         end
         FCS: begin
            vout_nxt    = 1'b1;
            dout_nxt    = fcs_byte;
            err_nxt     = bad && (fcs_idx == 2'd0);
            fcs_idx_nxt = fcs_idx + 2'd1;
            if (fcs_idx == 2'd3) begin
               gap_cnt_nxt = 16'd0;
               state_nxt   = (IFG == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            gap_cnt_nxt = gap_cnt + 16'd1;
            if (gap_cnt == GAP_LAST)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         dout    <= 8'h00;
         vout    <= 1'b0;
         err     <= 1'b0;
         crc     <= 32'hFFFFFFFF;
         cnt     <= 16'd0;
         pre_cnt <= 8'd0;
         fcs_idx <= 2'd0;
         gap_cnt <= 16'd0;
         bad     <= 1'b0;
      end else begin
         state   <= state_nxt;
         dout    <= dout_nxt;
         vout    <= vout_nxt;
         err     <= err_nxt;
         crc     <= crc_nxt;
         cnt     <= cnt_nxt;
         pre_cnt <= pre_cnt_nxt;
         fcs_idx <= fcs_idx_nxt;
         gap_cnt <= gap_cnt_nxt;
         bad     <= bad_nxt;
      end
   end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: default-parameter and MIN_LEN=0 instances, checked against a
// table-driven CRC frame model, a vector table, hand sequences and random frames.
module tb_mac_tx_framer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic       vin = 1'b0;
   logic       lin = 1'b0;
   logic       rdy0, vout0, err0, busy0, rdy1, vout1, err1, busy1;
   logic [7:0] dout0, dout1;
   bit         sel = 1'b0;

   always #5 clk = ~clk;

   mac_tx_framer dut0 (.clk(clk), .rst(rst), .din(din), .vin(vin), .lin(lin), .rdy(rdy0),
                       .dout(dout0), .vout(vout0), .err(err0), .busy(busy0));
   mac_tx_framer #(.MIN_LEN(0)) dut1 (.clk(clk), .rst(rst), .din(din), .vin(vin), .lin(lin), .rdy(rdy1),
                       .dout(dout1), .vout(vout1), .err(err1), .busy(busy1));

   logic       m_rdy, m_vout, m_err;
   logic [7:0] m_dout;
   always_comb begin
      m_rdy  = sel ? rdy1  : rdy0;
      m_vout = sel ? vout1 : vout0;
      m_err  = sel ? err1  : err0;
      m_dout = sel ? dout1 : dout0;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Capture of the selected instance: bytes, frame boundaries, gaps, err positions, rdy cycles.
   logic [7:0] cap[$];
   int fstart[$], fend[$], err_at[$], gap_len[$], rdy_hi[$];
   int idle_run = 0, rcnt = 0, stray = 0;
   logic pv = 1'b0;
   always @(negedge clk) begin
      if (m_vout) begin
         if (!pv) begin
            fstart.push_back(cap.size());
            gap_len.push_back(idle_run);
            rcnt = 0;
         end
         if (m_err) err_at.push_back(cap.size());
         if (m_rdy) rcnt++;
         cap.push_back(m_dout);
      end else begin
         if (pv) begin
            fend.push_back(cap.size());
            rdy_hi.push_back(rcnt);
            idle_run = 0;
         end
         idle_run++;
         if (m_err || m_rdy) stray++;
      end
      pv = m_vout;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Reference model
   logic [31:0] crc_tab[256];
   logic [7:0]  body_q[$];
   logic [7:0]  exp_q[$];
   int          exp_err_at, exp_rdy, last_fr;

   task automatic build_tab();
      logic [31:0] c;
      for (int i = 0; i < 256; i++) begin
         c = 32'(i);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crc_tab[i] = c;
      end
   endtask

   task automatic build_exp(input bit s, input int stop, input bit full);
      logic [31:0] c;
      logic [7:0]  b;
      int          minlen, plen;
      exp_q.delete();
      minlen = s ? 0 : 60;
      for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      plen = (stop > minlen) ? stop : minlen;
      c = 32'hFFFFFFFF;
      for (int k = 0; k < plen; k++) begin
         b = (k < stop) ? body_q[k] : 8'h00;
         exp_q.push_back(b);
         c = crc_tab[c[7:0] ^ b] ^ (c >> 8);
      end
      c = ~c;
      if (!full) c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
      exp_err_at = full ? -1 : 8 + plen;
      exp_rdy    = full ? stop : stop + 1;
   endtask

   task automatic fill_body(input int len, input int base);
      body_q.delete();
      for (int k = 0; k < len; k++)
         body_q.push_back((base < 0) ? 8'($urandom) : 8'(base + k));
   endtask

   function automatic int count_err(input int s, input int e);
      int n = 0;
      foreach (err_at[i]) if (err_at[i] >= s && err_at[i] < e) n++;
      return n;
   endfunction

   function automatic int first_err(input int s, input int e);
      foreach (err_at[i]) if (err_at[i] >= s && err_at[i] < e) return err_at[i] - s;
      return -1;
   endfunction

   // Present body_q[0..n-1] contiguously; leaves vin high so the caller decides when to drop it.
   task automatic send(input string name, input int n, input bit full);
      int i = 0, g = 0;
      bit acc;
      while (i < n && g < 400) begin
         vin = 1'b1;
         din = body_q[i];
         lin = full && (i == n - 1);
         @(negedge clk);
         acc = m_rdy;
         @(posedge clk);
         #1;
         if (acc) i++;
         g++;
      end
      lin = 1'b0;
      chk({name, "_accepted"}, i, n);
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while ((busy0 || busy1 || vout0 || vout1) && g < 1000) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (g >= 1000) chk({name, "_idle_timeout"}, g, 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string name, input int fi);
      int s, e, bad_i;
      s = fstart[fi];
      e = (fi < fend.size()) ? fend[fi] : cap.size();
      chk({name, "_vout_len"}, e - s, exp_q.size());
      bad_i = -1;
      for (int k = 0; k < exp_q.size() && k < e - s; k++)
         if (bad_i < 0 && cap[s + k] != exp_q[k]) bad_i = k;
      n_tests++;
      if (bad_i >= 0) begin
         n_fail++;
         $display("FAIL %s_bytes: byte %0d got %02h required %02h", name, bad_i, cap[s + bad_i], exp_q[bad_i]);
      end
      if (fi < rdy_hi.size()) chk({name, "_rdy_cycles"}, rdy_hi[fi], exp_rdy);
      chk({name, "_err_count"}, count_err(s, e), (exp_err_at < 0) ? 0 : 1);
      if (exp_err_at >= 0) chk({name, "_err_pos"}, first_err(s, e), exp_err_at);
   endtask

   task automatic run_frame(input string name, input bit s, input int stop, input bit full);
      int nfr;
      nfr = fstart.size();
      send(name, stop, full);
      vin = 1'b0;
      wait_idle(name);
      build_exp(s, stop, full);
      chk({name, "_frames"}, fstart.size() - nfr, 1);
      if (fstart.size() > nfr) check_frame(name, nfr);
      last_fr = nfr;
   endtask

   typedef struct {
      bit          s;
      int          len;
      int          stop;
      int          base;
      int          vlen;
      int          nerr;
      bit          chkf;
      logic [31:0] fcs;
   } vec_t;

   initial begin
      vec_t        vt[9];
      logic [7:0]  b1[$], b2[$];
      logic [31:0] fcs_seen;
      int          nfr, s0, e0;

      vt[0] = '{1'b1,  9,  9, 'h31, 21, 0, 1'b1, 32'hCBF43926};
      vt[1] = '{1'b0, 14, 14, 'h01, 72, 0, 1'b0, 32'h0};
      vt[2] = '{1'b0, 60, 60,   -1, 72, 0, 1'b0, 32'h0};
      vt[3] = '{1'b0,  1,  1, 'hA5, 72, 0, 1'b0, 32'h0};
      vt[4] = '{1'b0, 20, 10, 'h40, 72, 1, 1'b0, 32'h0};
      vt[5] = '{1'b0, 61, 61,   -1, 73, 0, 1'b0, 32'h0};
      vt[6] = '{1'b1,  1,  1, 'h00, 13, 0, 1'b0, 32'h0};
      vt[7] = '{1'b1, 30,  5,   -1, 17, 1, 1'b0, 32'h0};
      vt[8] = '{1'b0, 64, 64,   -1, 76, 0, 1'b0, 32'h0};

      build_tab();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dout",  dout0, 0);
      chk("rst_vout",  vout0, 0);
      chk("rst_rdy",   rdy0,  0);
      chk("rst_err",   err0,  0);
      chk("rst_busy",  busy0, 0);
      chk("rst_vout1", vout1, 0);
      chk("rst_busy1", busy1, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      foreach (vt[i]) begin
         sel = vt[i].s;
         fill_body(vt[i].len, vt[i].base);
         run_frame($sformatf("vec%0d", i), vt[i].s, vt[i].stop, vt[i].stop == vt[i].len);
         if (last_fr < fend.size()) begin
            s0 = fstart[last_fr];
            e0 = fend[last_fr];
            chk($sformatf("vec%0d_vlen", i), e0 - s0, vt[i].vlen);
            chk($sformatf("vec%0d_nerr", i), count_err(s0, e0), vt[i].nerr);
            if (vt[i].chkf) begin
               fcs_seen = {cap[e0 - 1], cap[e0 - 2], cap[e0 - 3], cap[e0 - 4]};
               chk($sformatf("vec%0d_fcs", i), fcs_seen, vt[i].fcs);
            end
         end
      end

      // Back-to-back 64-byte frames with vin held high across the boundary.
      sel = 1'b0;
      nfr = fstart.size();
      fill_body(64, -1);
      b1 = body_q;
      fill_body(64, -1);
      b2 = body_q;
      body_q = b1;
      send("b2b_f1", 64, 1'b1);
      body_q = b2;
      send("b2b_f2", 64, 1'b1);
      vin = 1'b0;
      wait_idle("b2b");
      chk("b2b_frames", fstart.size() - nfr, 2);
      if (fstart.size() >= nfr + 2) begin
         chk("b2b_gap", gap_len[nfr + 1], 12);
         body_q = b1;
         build_exp(1'b0, 64, 1'b1);
         check_frame("b2b_f1", nfr);
         body_q = b2;
         build_exp(1'b0, 64, 1'b1);
         check_frame("b2b_f2", nfr + 1);
      end

      // Reset while byte 5 is being presented.
      sel = 1'b0;
      nfr = fstart.size();
      fill_body(20, 'h70);
      send("rstmid", 4, 1'b0);
      din = body_q[4];
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      vin = 1'b0;
      @(negedge clk);
      chk("rstmid_vout", vout0, 0);
      chk("rstmid_dout", dout0, 0);
      chk("rstmid_busy", busy0, 0);
      chk("rstmid_rdy",  rdy0,  0);
      @(posedge clk);
      #1;
      vin = 1'b1;
      din = body_q[0];
      @(negedge clk);
      chk("restart_not_early", vout0, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("restart_vout", vout0, 1);
      chk("restart_dout", dout0, 8'h55);
      send("restart", 20, 1'b1);
      vin = 1'b0;
      wait_idle("restart");
      chk("rstmid_frames", fstart.size() - nfr, 2);
      if (fend.size() >= nfr + 2) begin
         chk("rstmid_trunc_len", fend[nfr] - fstart[nfr], 12);
         build_exp(1'b0, 20, 1'b1);
         check_frame("restart", nfr + 1);
      end

      // Random frames against the model.
      for (int r = 0; r < 30; r++) begin
         int  len, stop;
         bit  s, full;
         s    = 1'($urandom_range(0, 1));
         len  = int'($urandom_range(1, 90));
         full = ($urandom_range(0, 3) != 0) || (len == 1);
         stop = full ? len : int'($urandom_range(1, len - 1));
         sel  = s;
         fill_body(len, -1);
         run_frame($sformatf("rand%0d", r), s, stop, full);
      end

      chk("stray_rdy_err_while_idle", stray, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
